match_logger: RTL and testbench

MATCH_LOGGER -- requirements
Module: match_logger

---
 rtl/match_logger_if.sv | 21 ++
 rtl/match_logger.sv | 170 +++++++++++++++++
 tb/tb_match_logger.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/match_logger_if.sv
// Avalon-MM write-master bus carrying match log records out of match_logger.
interface match_logger_if;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;

    modport master (
        output avm_address,
        output avm_write,
        output avm_writedata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_write,
        input  avm_writedata,
        output avm_waitrequest
    );
endinterface

// File: rtl/match_logger.sv
// Logs one record per inc_addr request into a circular word buffer over Avalon-MM.
// Optional feature macro: MATCH_LOGGER_TIMESTAMP_EN appends a cycle-count timestamp word.
module match_logger #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  inc_addr,
    input  logic                  port_match,
    input  logic                  ip_match,
    input  logic                  mac_match,
    input  logic                  url_match,
    input  logic [15:0]           pkt_len,
    match_logger_if.master        avm,
    output logic                  busy,
    output logic [15:0]           rec_count,
    output logic [7:0]            dropped
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_HDR = 2'd1,
        WR_TS  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [11:0]   seq_q, seq_d;
    logic [15:0]   rec_count_q, rec_count_d;
    logic [7:0]    dropped_q, dropped_d;
    logic [3:0]    flags_q, flags_d;
    logic [15:0]   len_q, len_d;
    logic          avm_write_q, avm_write_d;
    logic [31:0]   avm_address_q, avm_address_d;
    logic [31:0]   avm_writedata_q, avm_writedata_d;
    logic          busy_q, busy_d;
    logic          accept_c;
    logic [31:0]   ts_word_c;
`ifdef MATCH_LOGGER_TIMESTAMP_EN
    logic [31:0]   ts_q, ts_d;
    logic [31:0]   ts_hold_q, ts_hold_d;
`endif

    assign accept_c = avm_write_q && !avm.avm_waitrequest;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q         <= IDLE;
            wptr_q          <= '0;
            seq_q           <= '0;
            rec_count_q     <= '0;
            dropped_q       <= '0;
            flags_q         <= '0;
            len_q           <= '0;
            avm_write_q     <= 1'b0;
            avm_address_q   <= BASE_ADDR;
            avm_writedata_q <= '0;
            busy_q          <= 1'b0;
`ifdef MATCH_LOGGER_TIMESTAMP_EN
            ts_q            <= '0;
            ts_hold_q       <= '0;
`endif
        end else begin
            state_q         <= state_d;
            wptr_q          <= wptr_d;
            seq_q           <= seq_d;
            rec_count_q     <= rec_count_d;
            dropped_q       <= dropped_d;
            flags_q         <= flags_d;
            len_q           <= len_d;
            avm_write_q     <= avm_write_d;
            avm_address_q   <= avm_address_d;
            avm_writedata_q <= avm_writedata_d;
            busy_q          <= busy_d;
`ifdef MATCH_LOGGER_TIMESTAMP_EN
            ts_q            <= ts_d;
            ts_hold_q       <= ts_hold_d;
`endif
        end
    end

    // Next state, capture, pointer and counter updates
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        seq_d       = seq_q;
        rec_count_d = rec_count_q;
        dropped_d   = dropped_q;
        flags_d     = flags_q;
        len_d       = len_q;
`ifdef MATCH_LOGGER_TIMESTAMP_EN
        ts_d        = ts_q + 32'd1;
        ts_hold_d   = ts_hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (inc_addr) begin
                    state_d = WR_HDR;
                    flags_d = {url_match, mac_match, ip_match, port_match};
                    len_d   = pkt_len;
`ifdef MATCH_LOGGER_TIMESTAMP_EN
                    ts_hold_d = ts_q;
`endif
                end
            end
            WR_HDR: begin
                if (accept_c) begin
                    wptr_d = wptr_q + AW'(1);
`ifdef MATCH_LOGGER_TIMESTAMP_EN
                    state_d = WR_TS;
`else
                    state_d     = IDLE;
                    seq_d       = seq_q + 12'd1;
                    rec_count_d = rec_count_q + 16'd1;
`endif
                end
            end
            WR_TS: begin
                if (accept_c) begin
                    wptr_d      = wptr_q + AW'(1);
                    state_d     = IDLE;
                    seq_d       = seq_q + 12'd1;
                    rec_count_d = rec_count_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Requests arriving outside IDLE are counted, never queued
        if (inc_addr && (state_q != IDLE) && (dropped_q != 8'hFF)) begin
            dropped_d = dropped_q + 8'd1;
        end
    end

`ifdef MATCH_LOGGER_TIMESTAMP_EN
    assign ts_word_c = ts_hold_d;
`else
    assign ts_word_c = 32'd0;
`endif

    // Registered bus outputs derived from the upcoming state
    always_comb begin
        avm_write_d     = 1'b0;
        busy_d          = 1'b0;
        avm_address_d   = BASE_ADDR + 32'({wptr_d, 2'b00});
        avm_writedata_d = '0;
        case (state_d)
            WR_HDR: begin
                avm_write_d     = 1'b1;
                busy_d          = 1'b1;
                avm_writedata_d = {flags_d, seq_d, len_d};
            end
            WR_TS: begin
                avm_write_d     = 1'b1;
                busy_d          = 1'b1;
                avm_writedata_d = ts_word_c;
            end
            default: ;
        endcase
    end

    assign avm.avm_write     = avm_write_q;
    assign avm.avm_address   = avm_address_q;
    assign avm.avm_writedata = avm_writedata_q;
    assign busy              = busy_q;
    assign rec_count         = rec_count_q;
    assign dropped           = dropped_q;
endmodule

// File: tb/tb_match_logger.sv
// Directed bench for match_logger: record layout, stalls, wrap, drops, reset behaviour.
module tb_match_logger;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        inc_addr;
    logic        port_match, ip_match, mac_match, url_match;
    logic [15:0] pkt_len;
    logic        busy;
    logic [15:0] rec_count;
    logic [7:0]  dropped;

    match_logger_if bus ();

    match_logger #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .n_rst(n_rst), .inc_addr(inc_addr),
        .port_match(port_match), .ip_match(ip_match),
        .mac_match(mac_match), .url_match(url_match),
        .pkt_len(pkt_len), .avm(bus.master),
        .busy(busy), .rec_count(rec_count), .dropped(dropped)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          exp_wptr = 0;
    logic [11:0] exp_seq  = '0;
    logic [15:0] exp_rec  = '0;

`ifdef MATCH_LOGGER_TIMESTAMP_EN
    logic [31:0] tb_cyc = '0;
    logic [31:0] exp_ts;
    always @(posedge clk) tb_cyc <= (!n_rst) ? 32'd0 : tb_cyc + 32'd1;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int w);
        return BASE + 32'(w * 4);
    endfunction

    task automatic set_flags(input logic [3:0] fl);
        {url_match, mac_match, ip_match, port_match} = fl;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        @(negedge clk);
        check("rst_write", 32'(bus.avm_write), 32'd0);
        check("rst_addr", bus.avm_address, BASE);
        check("rst_data", bus.avm_writedata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rec", 32'(rec_count), 32'd0);
        check("rst_drop", 32'(dropped), 32'd0);
        exp_wptr = 0;
        exp_seq  = '0;
        exp_rec  = '0;
        bus.avm_waitrequest = 1'b0;
        n_rst = 1'b1;
    endtask

    // Issue one request, stall the header for 'waits' cycles, then drain the record
    task automatic do_record(input logic [3:0] fl, input logic [15:0] len, input int waits);
        logic [31:0] hdr;
        hdr = {fl, exp_seq, len};
        set_flags(fl);
        pkt_len  = len;
        inc_addr = 1'b1;
        bus.avm_waitrequest = (waits > 0);
`ifdef MATCH_LOGGER_TIMESTAMP_EN
        exp_ts = tb_cyc;
`endif
        @(negedge clk);
        inc_addr = 1'b0;
        set_flags(4'b0000);
        check("hdr_write", 32'(bus.avm_write), 32'd1);
        check("hdr_busy", 32'(busy), 32'd1);
        check("hdr_addr", bus.avm_address, addr_of(exp_wptr));
        check("hdr_data", bus.avm_writedata, hdr);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check("stall_write", 32'(bus.avm_write), 32'd1);
            check("stall_addr", bus.avm_address, addr_of(exp_wptr));
            check("stall_data", bus.avm_writedata, hdr);
        end
        bus.avm_waitrequest = 1'b0;
        @(negedge clk);
        exp_wptr = (exp_wptr + 1) % DEPTH;
`ifdef MATCH_LOGGER_TIMESTAMP_EN
        check("ts_write", 32'(bus.avm_write), 32'd1);
        check("ts_addr", bus.avm_address, addr_of(exp_wptr));
        check("ts_data", bus.avm_writedata, exp_ts);
        check("ts_rec_hold", 32'(rec_count), 32'(exp_rec));
        @(negedge clk);
        exp_wptr = (exp_wptr + 1) % DEPTH;
`endif
        exp_seq++;
        exp_rec++;
        check("done_write", 32'(bus.avm_write), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        check("done_rec", 32'(rec_count), 32'(exp_rec));
        check("idle_addr", bus.avm_address, addr_of(exp_wptr));
    endtask

    initial begin
        n_rst = 1'b0;
        inc_addr = 1'b0;
        set_flags(4'b0000);
        pkt_len = '0;
        bus.avm_waitrequest = 1'b0;

        // Basic record, stalled record with zero flags, then wrap of the buffer
        do_reset();
        do_record(4'b0010, 16'd64, 0);
        do_record(4'b0000, 16'h05DC, 5);
        do_record(4'b1000, 16'h0001, 0);
        do_record(4'b0101, 16'hFFFF, 2);
        do_record(4'b1111, 16'h0100, 0);
        check("seq_after5", 32'(exp_seq), 32'(rec_count[11:0]));

        // Reset mid-write abandons the record; request on first edge after release is honoured
        set_flags(4'b1111);
        pkt_len = 16'h0BAD;
        inc_addr = 1'b1;
        bus.avm_waitrequest = 1'b1;
        @(negedge clk);
        inc_addr = 1'b0;
        check("midrst_write_pre", 32'(bus.avm_write), 32'd1);
        do_reset();
        do_record(4'b0100, 16'd20, 0);

        // Request on the edge that returns to IDLE is dropped
        set_flags(4'b0001);
        pkt_len = 16'd7;
        inc_addr = 1'b1;
        @(negedge clk);
        inc_addr = 1'b0;
        check("ret_hdr", bus.avm_writedata, {4'b0001, exp_seq, 16'd7});
`ifdef MATCH_LOGGER_TIMESTAMP_EN
        @(negedge clk);
        exp_wptr = (exp_wptr + 1) % DEPTH;
`endif
        inc_addr = 1'b1;
        @(negedge clk);
        inc_addr = 1'b0;
        exp_wptr = (exp_wptr + 1) % DEPTH;
        exp_seq++;
        exp_rec++;
        check("ret_drop", 32'(dropped), 32'd1);
        check("ret_write", 32'(bus.avm_write), 32'd0);
        check("ret_rec", 32'(rec_count), 32'(exp_rec));

        // Drops while stalled, then saturation
        do_reset();
        set_flags(4'b0001);
        pkt_len = 16'd100;
        inc_addr = 1'b1;
        bus.avm_waitrequest = 1'b1;
        @(negedge clk);
        set_flags(4'b1110);
        pkt_len = 16'hDEAD;
        for (int i = 0; i < 3; i++) @(negedge clk);
        inc_addr = 1'b0;
        check("drop3", 32'(dropped), 32'd3);
        check("drop_busy", 32'(busy), 32'd1);
        check("drop_hdr_kept", bus.avm_writedata, 32'h1000_0064);
        inc_addr = 1'b1;
        for (int i = 0; i < 297; i++) @(negedge clk);
        inc_addr = 1'b0;
        check("drop_sat", 32'(dropped), 32'hFF);
        bus.avm_waitrequest = 1'b0;
        @(negedge clk);
`ifdef MATCH_LOGGER_TIMESTAMP_EN
        @(negedge clk);
`endif
        check("drop_rec", 32'(rec_count), 32'd1);
        check("drop_sat_hold", 32'(dropped), 32'hFF);
        exp_wptr = 0;
        exp_seq = '0;
        exp_rec = '0;

`ifdef MATCH_LOGGER_TIMESTAMP_EN
        // Timestamp captured 100 cycles after reset
        do_reset();
        repeat (100) @(negedge clk);
        check("ts_cyc100", tb_cyc, 32'd100);
        do_record(4'b0010, 16'd64, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
